// File: rtl/serial_led_shift_drv.sv
// Serial driver for a shift-register LED chain: shifts a WIDTH-bit pattern out on
// led_do/led_clk at a divided rate, then raises led_pen to latch it into the chain.
module serial_led_shift_drv #(
   parameter int WIDTH       = 16,
   parameter int CLK_DIV     = 2,
   parameter int INVERT      = 1,
   parameter int LSB_FIRST   = 0,
   parameter int CHANGE_TRIG = 1,
   parameter int REFRESH_CYC = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic             load,
   output logic             busy,
   output logic             done,
   output logic             led_do,
   output logic             led_clk,
   output logic             led_clr,
   output logic             led_pen
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int REF_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'((REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0);
   localparam logic             INV_BIT  = (INVERT != 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_LATCH
   } state_t;

   state_t             r_state;
   logic [DIV_W-1:0]   r_div;
   logic [CNT_W-1:0]   r_bitcnt;
   logic [WIDTH-1:0]   r_shift;
   logic [WIDTH-1:0]   r_last;
   logic               r_pending;
   logic [REF_W-1:0]   r_refresh;
   logic               r_busy;
   logic               r_done;
   logic               r_led_do;
   logic               r_led_clk;
   logic               r_led_clr;
   logic               r_led_pen;

   state_t             w_state_nxt;
   logic [DIV_W-1:0]   w_div_nxt;
   logic [CNT_W-1:0]   w_bitcnt_nxt;
   logic [WIDTH-1:0]   w_shift_nxt;
   logic [WIDTH-1:0]   w_last_nxt;
   logic               w_pending_nxt;
   logic [REF_W-1:0]   w_refresh_nxt;
   logic               w_div_last;
   logic               w_start;
   logic               w_bit;
   logic               w_led_do_nxt;
   logic               w_shifting_nxt;

   always_comb begin
      w_div_last    = (r_div == DIV_LAST);
      w_start       = load || r_pending
                      || ((CHANGE_TRIG != 0) && (data != r_last))
                      || ((REFRESH_CYC > 0) && (r_refresh == REF_LAST));
      w_state_nxt   = r_state;
      w_div_nxt     = w_div_last ? '0 : r_div + 1'b1;
      w_bitcnt_nxt  = r_bitcnt;
      w_shift_nxt   = r_shift;
      w_last_nxt    = r_last;
      w_pending_nxt = r_pending || load;
      w_refresh_nxt = '0;

      case (r_state)
         ST_IDLE: begin
            w_div_nxt     = '0;
            w_pending_nxt = r_pending;
            if (w_start) begin
               w_state_nxt   = ST_SHIFT_LO;
               w_shift_nxt   = data;
               w_last_nxt    = data;
               w_pending_nxt = 1'b0;
               w_bitcnt_nxt  = CNT_FULL;
            end else begin
               w_refresh_nxt = r_refresh + 1'b1;
            end
         end
         ST_SHIFT_LO: begin
            if (w_div_last) w_state_nxt = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (w_div_last) begin
               w_shift_nxt  = (LSB_FIRST != 0) ? {1'b0, r_shift[WIDTH-1:1]}
                                               : {r_shift[WIDTH-2:0], 1'b0};
               w_bitcnt_nxt = r_bitcnt - 1'b1;
               w_state_nxt  = (r_bitcnt == CNT_ONE) ? ST_LATCH : ST_SHIFT_LO;
            end
         end
         ST_LATCH: begin
            if (w_div_last) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Outputs are registered from next-state values so pins never see input glitches
      w_bit          = (LSB_FIRST != 0) ? w_shift_nxt[0] : w_shift_nxt[WIDTH-1];
      w_led_do_nxt   = (w_state_nxt == ST_SHIFT_LO) ? (w_bit ^ INV_BIT) : r_led_do;
      w_shifting_nxt = (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_div     <= '0;
         r_bitcnt  <= '0;
         r_last    <= '0;
         r_pending <= 1'b0;
         r_refresh <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_led_do  <= 1'b0;
         r_led_clk <= 1'b0;
         r_led_clr <= 1'b0;
         r_led_pen <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_last    <= w_last_nxt;
         r_pending <= w_pending_nxt;
         r_refresh <= w_refresh_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= (w_state_nxt == ST_LATCH) && (w_div_nxt == DIV_LAST);
         r_led_do  <= w_led_do_nxt;
         r_led_clk <= (w_state_nxt == ST_SHIFT_HI);
         r_led_clr <= 1'b1;
         r_led_pen <= !w_shifting_nxt;
      end
   end

   // Pattern register is pure data; it is always reloaded before use
   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign led_do  = r_led_do;
   assign led_clk = r_led_clk;
   assign led_clr = r_led_clr;
   assign led_pen = r_led_pen;

endmodule

// File: tb/tb_serial_led_shift_drv.sv
// Bench for serial_led_shift_drv: two instances (MSB-first inverted with change trigger,
// LSB-first plain with auto-refresh) checked every cycle against a frame-offset model.
module tb_serial_led_shift_drv;
   localparam int W = 16;
   localparam int D = 2;
   localparam int F = 2 * D * W + D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [W-1:0] data_a, data_b;
   logic         load_a, load_b;
   logic         busy_a, done_a, do_a, lclk_a, clr_a, pen_a;
   logic         busy_b, done_b, do_b, lclk_b, clr_b, pen_b;

   serial_led_shift_drv #(.WIDTH(W), .CLK_DIV(D), .INVERT(1), .LSB_FIRST(0),
                          .CHANGE_TRIG(1), .REFRESH_CYC(0)) u_dut_a (
      .clk(clk), .reset(reset), .data(data_a), .load(load_a),
      .busy(busy_a), .done(done_a), .led_do(do_a), .led_clk(lclk_a),
      .led_clr(clr_a), .led_pen(pen_a));

   serial_led_shift_drv #(.WIDTH(W), .CLK_DIV(D), .INVERT(0), .LSB_FIRST(1),
                          .CHANGE_TRIG(0), .REFRESH_CYC(100)) u_dut_b (
      .clk(clk), .reset(reset), .data(data_b), .load(load_b),
      .busy(busy_b), .done(done_b), .led_do(do_b), .led_clk(lclk_b),
      .led_clr(clr_b), .led_pen(pen_b));

   // Model: k = cycle offset inside the current frame (-1 when idle)
   typedef struct {
      int           k;
      logic [W-1:0] fdata;
      logic [W-1:0] last;
      bit           pend;
      int           refc;
      bit           ledo;
      bit           clr;
   } mdl_t;

   typedef struct {
      int           sel;
      logic [W-1:0] din;
      logic [W-1:0] ser;
      int           nbusy;
      int           npen;
   } vec_t;

   mdl_t         m [2];
   vec_t         tbl [6];
   int           rise [2], busyc [2], donec [2], penlo [2], idlerun [2], gap [2];
   logic [W-1:0] cap [2];
   logic         pclk [2];
   int           checks = 0;
   int           failures = 0;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.k = -1; r.fdata = '0; r.last = '0; r.pend = 1'b0;
      r.refc = 0; r.ledo = 1'b0; r.clr = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(mdl_t mi, bit inv, bit lsb, bit ct, int rc,
                                     logic [W-1:0] din, bit ld);
      mdl_t mo;
      bit   st;
      int   b;
      mo = mi;
      mo.clr = 1'b1;
      if (mo.k < 0) begin
         st = ld || mo.pend || (ct && (din != mo.last)) || ((rc > 0) && (mo.refc == rc - 1));
         if (st) begin
            mo.k = 0; mo.fdata = din; mo.last = din; mo.pend = 1'b0; mo.refc = 0;
         end else begin
            mo.refc++;
         end
      end else begin
         if (ld) mo.pend = 1'b1;
         mo.k++;
         if (mo.k == F) mo.k = -1;
         mo.refc = 0;
      end
      if (mo.k >= 0 && mo.k < 2 * D * W) begin
         b = mo.k / (2 * D);
         mo.ledo = (lsb ? mo.fdata[b] : mo.fdata[W-1-b]) ^ inv;
      end
      return mo;
   endfunction

   // {busy, done, led_do, led_clk, led_clr, led_pen}
   function automatic logic [5:0] mdl_out(mdl_t mm);
      logic sh, bz, dn, ck;
      sh = (mm.k >= 0) && (mm.k < 2 * D * W);
      bz = (mm.k >= 0);
      dn = (mm.k == F - 1);
      ck = sh && (((mm.k / D) % 2) == 1);
      return {bz, dn, mm.ledo, ck, mm.clr, ~sh};
   endfunction

   function automatic logic [5:0] dut_out(int s);
      if (s == 0) return {busy_a, done_a, do_a, lclk_a, clr_a, pen_a};
      return {busy_b, done_b, do_b, lclk_b, clr_b, pen_b};
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      logic [5:0] o;
      @(posedge clk);
      if (!reset) begin
         m[0] = mdl_reset();
         m[1] = mdl_reset();
      end else begin
         m[0] = mdl_step(m[0], 1'b1, 1'b0, 1'b1, 0,   data_a, load_a);
         m[1] = mdl_step(m[1], 1'b0, 1'b1, 1'b0, 100, data_b, load_b);
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         o = dut_out(s);
         chk($sformatf("cyc%0d", s), o, mdl_out(m[s]));
         if (o[2] && !pclk[s]) begin
            rise[s]++;
            cap[s] = {cap[s][W-2:0], o[3]};
         end
         pclk[s] = o[2];
         if (o[5]) begin
            busyc[s]++;
            if (idlerun[s] > 0) gap[s] = idlerun[s];
            idlerun[s] = 0;
         end else begin
            idlerun[s]++;
         end
         if (o[4]) donec[s]++;
         if (!o[0]) penlo[s]++;
      end
   endtask

   task automatic clr_stats(int s);
      rise[s] = 0; busyc[s] = 0; donec[s] = 0; penlo[s] = 0; gap[s] = 0; cap[s] = '0;
   endtask

   task automatic pulse_load(int s);
      if (s == 0) load_a = 1'b1; else load_b = 1'b1;
      step();
      load_a = 1'b0;
      load_b = 1'b0;
   endtask

   task automatic wait_idle(int s, string name);
      int n;
      logic [5:0] o;
      n = 0;
      o = dut_out(s);
      while (o[5] && n < 500) begin
         step();
         o = dut_out(s);
         n++;
      end
      chk(name, o[5], 1'b0);
   endtask

   task automatic wait_busy(int s, string name);
      int n;
      logic [5:0] o;
      n = 0;
      o = dut_out(s);
      while (!o[5] && n < 300) begin
         step();
         o = dut_out(s);
         n++;
      end
      chk(name, o[5], 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0] = '{0, 16'hA5C3, 16'h5A3C, 66, 64};
      tbl[1] = '{0, 16'hFFFF, 16'h0000, 66, 64};
      tbl[2] = '{0, 16'h0001, 16'hFFFE, 66, 64};
      tbl[3] = '{0, 16'h8000, 16'h7FFF, 66, 64};
      tbl[4] = '{1, 16'h0001, 16'h8000, 66, 64};
      tbl[5] = '{1, 16'hA5C3, 16'hC3A5, 66, 64};
      for (int s = 0; s < 2; s++) begin
         m[s] = mdl_reset();
         pclk[s] = 1'b0;
         idlerun[s] = 0;
         clr_stats(s);
      end
      reset = 1'b1; data_a = '0; data_b = '0; load_a = 1'b0; load_b = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("rst_a", dut_out(0), 6'b000001);
      chk("rst_b", dut_out(1), 6'b000001);
      step();
      step();
      reset = 1'b1;
      step();
      chk("clr_rel_a", clr_a, 1'b1);
      chk("clr_rel_b", clr_b, 1'b1);

      for (int i = 0; i < 6; i++) begin
         int s;
         s = tbl[i].sel;
         wait_idle(s, "tbl_idle");
         if (s == 0) data_a = tbl[i].din; else data_b = tbl[i].din;
         clr_stats(s);
         pulse_load(s);
         wait_idle(s, "tbl_end");
         chk($sformatf("tbl%0d_ser", i), cap[s], tbl[i].ser);
         chk($sformatf("tbl%0d_rises", i), rise[s], 16);
         chk($sformatf("tbl%0d_busy", i), busyc[s], tbl[i].nbusy);
         chk($sformatf("tbl%0d_done", i), donec[s], 1);
         chk($sformatf("tbl%0d_penlo", i), penlo[s], tbl[i].npen);
      end

      // change trigger without load
      data_a = 16'h0000;
      pulse_load(0);
      wait_idle(0, "ct_prep");
      clr_stats(0);
      data_a = 16'h00FF;
      step();
      chk("ct_start", busy_a, 1'b1);
      repeat (300) step();
      chk("ct_frames", donec[0], 1);
      chk("ct_ser", cap[0], 16'hFF00);

      // repeated loads mid-frame collapse into one follow-on frame
      clr_stats(0);
      data_a = 16'h0F0F;
      pulse_load(0);
      repeat (10) step();
      data_a = 16'h1234;
      pulse_load(0);
      repeat (5) step();
      pulse_load(0);
      repeat (5) step();
      pulse_load(0);
      repeat (200) step();
      chk("pend_frames", donec[0], 2);
      chk("pend_gap", gap[0], 1);
      chk("pend_ser", cap[0], 16'hEDCB);

      // load coinciding with done
      clr_stats(0);
      data_a = 16'h4321;
      pulse_load(0);
      n = 0;
      while (!done_a && n < 200) begin
         step();
         n++;
      end
      chk("dl_done_seen", done_a, 1'b1);
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      chk("dl_idle_between", busy_a, 1'b0);
      step();
      chk("dl_restart", busy_a, 1'b1);
      repeat (150) step();
      chk("dl_frames", donec[0], 2);
      chk("dl_gap", gap[0], 1);

      // periodic refresh on instance B
      wait_busy(1, "ref_sync_busy");
      wait_idle(1, "ref_sync_idle");
      clr_stats(1);
      repeat (400) step();
      chk("ref_frames", donec[1], 2);
      chk("ref_gap", gap[1], 100);
      wait_busy(1, "ref_sync2_busy");
      wait_idle(1, "ref_sync2_idle");
      repeat (49) step();
      pulse_load(1);
      chk("ref_load_start", busy_b, 1'b1);
      chk("ref_load_gap", gap[1], 50);
      wait_idle(1, "ref_load_end");
      repeat (120) step();
      chk("ref_after_load_gap", gap[1], 100);

      // asynchronous reset during bit 7
      wait_idle(0, "rm_idle");
      clr_stats(0);
      data_a = 16'h5555;
      pulse_load(0);
      n = 0;
      while (rise[0] < 7 && n < 200) begin
         step();
         n++;
      end
      repeat (2) step();
      chk("rm_in_frame", busy_a, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("rm_a", dut_out(0), 6'b000001);
      chk("rm_b", dut_out(1), 6'b000001);
      m[0] = mdl_reset();
      m[1] = mdl_reset();
      pclk[0] = 1'b0;
      pclk[1] = 1'b0;
      chk("rm_no_done", donec[0], 0);
      step();
      reset = 1'b1;
      step();
      chk("rm_clr_rel", clr_a, 1'b1);
      repeat (100) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
